// File: rtl/proj001_pkg.sv
// Shared definitions for the proj001 operand/op capture interface:
// operation codes, default field widths and the issuer state encoding.
package proj001_pkg;

  localparam int DEF_D_W  = 4;
  localparam int DEF_OP_W = 2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BEAT_A = 3'd1,
    BEAT_B = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } issuer_state_e;

endpackage

// File: rtl/proj001_wait_timer.sv
// Clear/enable wait counter for the issuer; tc_o flags the last cycle a
// responder valid can still be accepted before the issuer times out.
module proj001_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clock,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  // The cycle holding count MAX_WAIT-2 is the one whose increment reaches MAX_WAIT-1.
  localparam logic [CW-1:0] TC_VAL = CW'(MAX_WAIT - 2);

  logic [CW-1:0] count_q, count_d;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !tc_o) begin
      count_d = count_q + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/proj001_issuer.sv
// Initiator for the proj001 capture interface: serialises one request as two
// capture beats, awaits the responder and returns result or timeout.
// Optional macro PROJ001_ISSUER_STATS_EN adds saturating completion counters.
module proj001_issuer
  import proj001_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int OP_W     = DEF_OP_W,
  parameter int D_W      = DEF_D_W
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic [D_W-1:0]  req_a,
  input  logic [D_W-1:0]  req_b,
  output logic            capture,
  output logic [OP_W-1:0] op,
  output logic [D_W-1:0]  d_in,
  input  logic            valid,
  input  logic [D_W:0]    result,
  output logic            rsp_valid,
  output logic [D_W:0]    rsp_result,
  output logic            rsp_timeout
`ifdef PROJ001_ISSUER_STATS_EN
  ,
  output logic [15:0]     stat_done,
  output logic [15:0]     stat_timeout
`endif
);

  issuer_state_e   state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [D_W-1:0]  d_in_q, d_in_d;
  logic [D_W-1:0]  b_q, b_d;
  logic            capture_q, capture_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [D_W:0]    rsp_result_q, rsp_result_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic            tmr_clr, tmr_en, tmr_tc;

  proj001_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clock(clock),
    .rst  (rst),
    .clr_i(tmr_clr),
    .en_i (tmr_en),
    .tc_o (tmr_tc)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    d_in_d        = d_in_q;
    b_d           = b_q;
    capture_d     = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_result_d  = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;
    tmr_clr       = 1'b0;
    tmr_en        = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d   = BEAT_A;
          op_d      = req_op;
          d_in_d    = req_a;
          b_d       = req_b;
          capture_d = 1'b1;
        end
      end
      BEAT_A: begin
        state_d   = BEAT_B;
        d_in_d    = b_q;
        capture_d = 1'b1;
      end
      BEAT_B: begin
        state_d = WAIT;
        tmr_clr = 1'b1;
      end
      WAIT: begin
        tmr_en = 1'b1;
        // A valid on the terminal-count cycle still wins over the timeout.
        if (valid) begin
          state_d       = RESP;
          rsp_valid_d   = 1'b1;
          rsp_result_d  = result;
          rsp_timeout_d = 1'b0;
        end else if (tmr_tc) begin
          state_d       = RESP;
          rsp_valid_d   = 1'b1;
          rsp_result_d  = '0;
          rsp_timeout_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q       <= IDLE;
      op_q          <= '0;
      d_in_q        <= '0;
      b_q           <= '0;
      capture_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      d_in_q        <= d_in_d;
      b_q           <= b_d;
      capture_q     <= capture_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign capture     = capture_q;
  assign op          = op_q;
  assign d_in        = d_in_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_timeout = rsp_timeout_q;

`ifdef PROJ001_ISSUER_STATS_EN
  logic [15:0] stat_done_q, stat_timeout_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      stat_done_q    <= '0;
      stat_timeout_q <= '0;
    end else begin
      if (rsp_valid_q && (stat_done_q != 16'hFFFF)) begin
        stat_done_q <= stat_done_q + 16'd1;
      end
      if (rsp_valid_q && rsp_timeout_q && (stat_timeout_q != 16'hFFFF)) begin
        stat_timeout_q <= stat_timeout_q + 16'd1;
      end
    end
  end

  assign stat_done    = stat_done_q;
  assign stat_timeout = stat_timeout_q;
`endif

endmodule
